// File: rtl/nukv_value_pkg.sv
// Shared types and header layout for the value reassembler.
// The header word is the length prefix that downstream write-back and network logic expect.
package nukv_value_pkg;

    typedef enum logic [1:0] {
        FILL,
        DROP,
        HDR,
        DRAIN
    } state_t;

    localparam int LEN_LSB = 0;
    localparam int LEN_W   = 16;
    localparam int CNT_LSB = 16;
    localparam int CNT_W   = 15;
    localparam int ERR_BIT = 31;

    // The byte length wraps at 16 bits; the word count field carries the full size.
    function automatic logic [31:0] make_header(input logic [CNT_W-1:0] words,
                                                input logic [LEN_W-1:0] bytes_per_word,
                                                input logic err);
        logic [31:0]      hdr;
        logic [LEN_W-1:0] len;
        len = {1'b0, words} * bytes_per_word;
        hdr = '0;
        hdr[LEN_LSB +: LEN_W] = len;
        hdr[CNT_LSB +: CNT_W] = words;
        hdr[ERR_BIT]          = err;
        return hdr;
    endfunction

endpackage

// File: rtl/nukv_value_buffer_ram.sv
// Value buffer: one write port and one registered read port.
// The contents are not reset, so the array can map onto block RAM.
module nukv_value_buffer_ram #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/nukv_value_reassembler.sv
// Buffers one segmented value and re-emits it as a length header followed by its data words.
// Values never overlap: input is refused while the header and data are being emitted.
module nukv_value_reassembler
    import nukv_value_pkg::*;
#(
    parameter int MEMORY_WIDTH = 512,
    parameter int MAX_WORDS    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MEMORY_WIDTH-1:0] input_data,
    input  logic                    input_valid,
    input  logic                    input_last,
    output logic                    input_ready,
    output logic [MEMORY_WIDTH-1:0] output_data,
    output logic                    output_valid,
    output logic                    output_last,
    input  logic                    output_ready
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    CNT_MAX        = CW'(MAX_WORDS);
    localparam logic [LEN_W-1:0] BYTES_PER_WORD = LEN_W'(MEMORY_WIDTH / 8);

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [AW-1:0]           rd, rd_n;
    logic                    err, err_n;
    logic                    in_ready_q, in_ready_n;
    logic                    valid_q, valid_n;
    logic                    last_q, last_n;
    logic [MEMORY_WIDTH-1:0] hdr_q, hdr_n;
    logic [MEMORY_WIDTH-1:0] ram_q;
    logic                    wr_en;
    logic                    in_fire;
    logic                    out_fire;

    assign in_fire  = input_valid & in_ready_q;
    assign out_fire = valid_q & output_ready;

    // Next-state logic; the buffer read address follows rd_n so the RAM output
    // already holds the next word (word 0 while in HDR) when DRAIN needs it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rd_n    = rd;
        err_n   = err;
        wr_en   = 1'b0;
        case (state)
            FILL: begin
                if (in_fire) begin
                    wr_en = 1'b1;
                    cnt_n = cnt + CW'(1);
                    if (input_last) begin
                        state_n = HDR;
                    end else if (cnt_n == CNT_MAX) begin
                        state_n = DROP;
                        err_n   = 1'b1;
                    end
                end
            end
            DROP: begin
                if (in_fire && input_last) begin
                    state_n = HDR;
                end
            end
            HDR: begin
                if (out_fire) begin
                    state_n = DRAIN;
                    rd_n    = '0;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if ({1'b0, rd} == cnt - CW'(1)) begin
                        state_n = FILL;
                        cnt_n   = '0;
                        rd_n    = '0;
                        err_n   = 1'b0;
                    end else begin
                        rd_n = rd + AW'(1);
                    end
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_comb begin
        hdr_n = '0;
        if (state_n == HDR) begin
            hdr_n[31:0] = make_header(CNT_W'(cnt_n), BYTES_PER_WORD, err_n);
        end
        valid_n    = (state_n == HDR) || (state_n == DRAIN);
        last_n     = (state_n == DRAIN) && (({1'b0, rd_n} + CW'(1)) == cnt_n);
        in_ready_n = (state_n == FILL) || (state_n == DROP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FILL;
            cnt        <= '0;
            rd         <= '0;
            err        <= 1'b0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            hdr_q      <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rd         <= rd_n;
            err        <= err_n;
            in_ready_q <= in_ready_n;
            valid_q    <= valid_n;
            last_q     <= last_n;
            hdr_q      <= hdr_n;
        end
    end

    nukv_value_buffer_ram #(
        .WIDTH (MEMORY_WIDTH),
        .DEPTH (MAX_WORDS),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cnt[AW-1:0]),
        .wr_data (input_data),
        .rd_addr (rd_n),
        .rd_data (ram_q)
    );

    assign input_ready  = in_ready_q;
    assign output_valid = valid_q;
    assign output_last  = last_q;
    assign output_data  = (state == DRAIN) ? ram_q : hdr_q;

endmodule

// File: tb/tb_nukv_value_reassembler.sv
// Directed and random-backpressure bench for nukv_value_reassembler.
// Expected header values in the table are hand-computed for 512-bit words and MAX_WORDS=32.
module tb_nukv_value_reassembler;

    localparam int MW   = 512;
    localparam int MAXW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] input_data;
    logic          input_valid;
    logic          input_last;
    logic          input_ready;
    logic [MW-1:0] output_data;
    logic          output_valid;
    logic          output_last;
    logic          output_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          words;
        logic [31:0] exp_hdr;
        int          exp_out;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    nukv_value_reassembler #(
        .MEMORY_WIDTH (MW),
        .MAX_WORDS    (MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_last   (input_last),
        .input_ready  (input_ready),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_last  (output_last),
        .output_ready (output_ready)
    );

    function automatic logic [MW-1:0] mk_word(input int id, input int i);
        logic [MW-1:0] w;
        for (int j = 0; j < MW / 32; j++) begin
            w[j*32 +: 32] = 32'(id * 65536 + i * 256 + j);
        end
        return w;
    endfunction

    function automatic logic [31:0] model_hdr(input int n);
        int          c;
        logic [31:0] h;
        c = (n > MAXW) ? MAXW : n;
        h = '0;
        h[15:0]  = 16'(c * (MW / 8));
        h[30:16] = 15'(c);
        h[31]    = (n > MAXW);
        return h;
    endfunction

    task automatic check_output(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one value word by word; returns aligned just after the edge that took the last word.
    task automatic apply_stimulus(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            int waited;
            input_valid = 1'b1;
            input_data  = mk_word(id, i);
            input_last  = (i == n - 1);
            waited = 0;
            @(negedge clk);
            while (!input_ready && waited < 200) begin
                waited++;
                @(negedge clk);
            end
            if (!input_ready) begin
                checks++;
                errors++;
                $display("[TB] FAIL input_ready_timeout: value %0d word %0d got ready=0 expected 1", id, i);
                input_valid = 1'b0;
                input_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    // Collects header plus n_out data words; output_valid must be high every cycle (no bubbles).
    task automatic receive_value(input int id, input int n_out, input logic [31:0] exp_hdr, input bit rand_ready);
        logic [MW-1:0] exp;
        logic [MW-1:0] held_d;
        logic          held_l;
        bit            stalled;
        int            k;
        int            cyc;
        stalled = 1'b0;
        held_d  = '0;
        held_l  = 1'b0;
        k       = 0;
        cyc     = 0;
        while (k <= n_out && cyc < 40 * (n_out + 2)) begin
            output_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (k == 0) begin
                exp = '0;
                exp[31:0] = exp_hdr;
            end else begin
                exp = mk_word(id, k - 1);
            end
            check_output("out_valid", MW'(output_valid), MW'(1'b1));
            if (stalled) begin
                check_output("stall_data", output_data, held_d);
                check_output("stall_last", MW'(output_last), MW'(held_l));
            end
            if (output_valid && output_ready) begin
                check_output(k == 0 ? "hdr_word" : "data_word", output_data, exp);
                check_output("out_last", MW'(output_last), MW'(k == n_out && k > 0));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = output_valid;
                held_d  = output_data;
                held_l  = output_last;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        if (k <= n_out) begin
            checks++;
            errors++;
            $display("[TB] FAIL output_timeout: value %0d got %0d words expected %0d", id, k, n_out + 1);
        end
        output_ready = 1'b1;
        @(negedge clk);
        check_output("ready_after_value", MW'(input_ready), MW'(1'b1));
        check_output("valid_after_value", MW'(output_valid), MW'(1'b0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        input_valid  = 1'b0;
        input_data   = '0;
        input_last   = 1'b0;
        output_ready = 1'b1;

        vecs[0] = '{words: 3,  exp_hdr: 32'h0003_00C0, exp_out: 3};
        vecs[1] = '{words: 1,  exp_hdr: 32'h0001_0040, exp_out: 1};
        vecs[2] = '{words: 40, exp_hdr: 32'h8020_0800, exp_out: 32};
        vecs[3] = '{words: 2,  exp_hdr: 32'h0002_0080, exp_out: 2};
        vecs[4] = '{words: 32, exp_hdr: 32'h0020_0800, exp_out: 32};
        vecs[5] = '{words: 33, exp_hdr: 32'h8020_0800, exp_out: 32};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_input_ready", MW'(input_ready), MW'(1'b0));
        check_output("rst_output_valid", MW'(output_valid), MW'(1'b0));
        check_output("rst_output_last", MW'(output_last), MW'(1'b0));
        check_output("rst_output_data", output_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("post_rst_ready", MW'(input_ready), MW'(1'b1));
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            apply_stimulus(v, vecs[v].words);
            receive_value(v, vecs[v].exp_out, vecs[v].exp_hdr, 1'b0);
        end

        for (int v = 100; v < 200; v++) begin
            int n;
            n = $urandom_range(1, MAXW);
            apply_stimulus(v, n);
            receive_value(v, n, model_hdr(n), 1'b1);
        end

        // Abort a 5-word value after two data words have left, then check the next value is clean.
        apply_stimulus(300, 5);
        output_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [MW-1:0] exp;
            @(negedge clk);
            if (k == 0) begin
                exp = '0;
                exp[31:0] = 32'h0005_0140;
            end else begin
                exp = mk_word(300, k - 1);
            end
            check_output("abort_valid", MW'(output_valid), MW'(1'b1));
            check_output("abort_word", output_data, exp);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("abort_rst_valid", MW'(output_valid), MW'(1'b0));
        check_output("abort_rst_last", MW'(output_last), MW'(1'b0));
        check_output("abort_rst_ready", MW'(input_ready), MW'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(301, 2);
        receive_value(301, 2, 32'h0002_0080, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
